// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC load and a single outstanding IMEM fetch, holds the word for decode.
// First if_valid >= 3 cycles after reset; HOLD stalls on if_ready, redirects flush and drop stale data.
module pc_fetch_ctrl #(
  parameter logic [31:0] START_PC = 32'h00400000,
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pc_en,
  output logic [31:0] o_npc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_fetch_cnt,
  output logic        o_fetch_err
);
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t          r_state, w_next;
  logic            r_kill, w_kill_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic            r_if_valid;
  logic [31:0]     r_if_pc, r_if_inst, r_fetch_cnt;
  logic            r_fetch_err;
  logic            w_capture, w_accept, w_active;

  assign w_active    = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_HOLD);
  assign o_imem_addr = i_pc;

  always_comb begin
    w_next     = r_state;
    w_kill_nxt = r_kill;
    w_to_nxt   = r_to_cnt;
    o_pc_en    = 1'b0;
    o_npc      = i_pc + 32'd4;
    o_imem_req = 1'b0;
    w_capture  = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_INIT: begin
        o_pc_en = 1'b1;
        o_npc   = START_PC;
        w_next  = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        w_to_nxt   = '0;
        w_next     = S_WAIT;
        if (i_redirect) w_kill_nxt = 1'b1;
      end
      S_WAIT: begin
        o_imem_req = 1'b1;
        if (i_imem_valid) begin
          w_kill_nxt = 1'b0;
          if (r_kill || i_redirect) begin
            w_next = S_FETCH;
          end else begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end
        end else begin
          // Redirect with the old request still outstanding: its response must be discarded.
          if (i_redirect) w_kill_nxt = 1'b1;
          if (r_to_cnt == TO_W'(TIMEOUT - 1)) w_next = S_HALT;
          else w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_next = S_FETCH;
        end else if (i_if_ready) begin
          o_pc_en  = 1'b1;
          w_accept = 1'b1;
          w_next   = S_FETCH;
        end
      end
      default: w_next = S_HALT;
    endcase
    if (i_redirect && w_active) begin
      o_pc_en = 1'b1;
      o_npc   = i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_kill      <= 1'b0;
      r_to_cnt    <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= 32'd0;
      r_fetch_cnt <= 32'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_kill     <= w_kill_nxt;
      r_to_cnt   <= w_to_nxt;
      r_if_valid <= w_capture || ((r_state == S_HOLD) && (w_next == S_HOLD));
      if (w_capture) begin
        r_if_pc   <= i_pc;
        r_if_inst <= i_imem_rdata;
      end
      if (w_accept) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_next == S_HALT) r_fetch_err <= 1'b1;
    end
  end

  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_inst   = r_if_inst;
  assign o_fetch_cnt = r_fetch_cnt;
  assign o_fetch_err = r_fetch_err;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: PC register and IMEM models, directed scenarios, then randomized traffic
// checked against an instruction-stream model (next delivered PC = last PC + 4 or latest redirect target).
module tb_pc_fetch_ctrl;
  localparam logic [31:0] START = 32'h00400000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        pc_en, imem_req, imem_valid, if_valid, fetch_err;
  logic [31:0] npc, imem_addr, imem_rdata, if_pc, if_inst, fetch_cnt;
  logic        redirect = 1'b0, if_ready = 1'b1;
  logic [31:0] redirect_pc = 32'd0;

  int n_checks = 0, n_errors = 0;

  pc_fetch_ctrl #(.START_PC(START), .TIMEOUT(4), .TO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .o_pc_en(pc_en), .o_npc(npc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_valid(imem_valid),
    .i_imem_rdata(imem_rdata), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_if_ready(if_ready), .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_inst(if_inst),
    .o_fetch_cnt(fetch_cnt), .o_fetch_err(fetch_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00000013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // PC register owned by the surrounding pipeline
  always @(posedge clk) if (pc_en) pc <= npc;

  // IMEM: one request at a time, latency 1..3 cycles (fixed or random), optional mute
  logic        mem_busy = 1'b0, mute = 1'b0;
  int          lat_mode = 1, rem = 0;
  logic [31:0] a_l;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy   <= 1'b0;
      imem_valid <= 1'b0;
      imem_rdata <= 32'd0;
      rem        <= 0;
    end else if (imem_valid) begin
      imem_valid <= 1'b0;
      mem_busy   <= 1'b0;
    end else if (mem_busy) begin
      if (rem <= 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= inst_of(a_l);
      end
      rem <= rem - 1;
    end else if (imem_req && !mute) begin
      int l;
      l = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      mem_busy <= 1'b1;
      a_l      <= imem_addr;
      rem      <= l - 1;
      if (l == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= inst_of(imem_addr);
      end
    end
  end

  // Instruction-stream reference model
  bit          mon_en = 1'b0;
  logic [31:0] exp_pc = START, m_cnt = 32'd0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("fetch_cnt", fetch_cnt, m_cnt);
      if (imem_req) chk("imem_addr", imem_addr, pc);
      if (redirect) begin
        chk("redir_npc", npc, redirect_pc);
        chk("redir_pc_en", 32'(pc_en), 32'd1);
        exp_pc = redirect_pc;
      end else if (if_valid && if_ready) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_inst", if_inst, inst_of(exp_pc));
        chk("seq_npc", npc, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        m_cnt  = m_cnt + 32'd1;
      end
    end
  end

  task automatic cyc_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int budget, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (if_valid && if_ready) ok = 1'b1;
    end
    chk("hs_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_vld(input int budget);
    for (int i = 0; i < budget && !if_valid; i++) @(negedge clk);
    chk("vld_seen", 32'(if_valid), 32'd1);
  endtask

  task automatic restart();
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    cyc_drive();
    rst    = 1'b0;
    exp_pc = START;
    m_cnt  = 32'd0;
    mon_en = 1'b1;
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_npc", npc, START);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    cyc_drive();
    rst = 1'b0;
    mon_en = 1'b1;

    // Back-to-back sequential fetches, latency 1
    for (int k = 0; k < 3; k++) begin
      wait_hs(10, c);
      chk("boot_pc", if_pc, START + 32'(4 * k));
      chk("hs_gap", 32'(c), (k == 0) ? 32'd4 : 32'd3);
    end
    @(negedge clk);
    chk("cnt3", fetch_cnt, 32'd3);

    // Decode stall in HOLD
    cyc_drive();
    if_ready = 1'b0;
    wait_vld(10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, START + 32'd12);
      chk("stall_inst", if_inst, inst_of(START + 32'd12));
      chk("stall_pc_en", 32'(pc_en), 32'd0);
      chk("stall_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    lat_mode = 2;
    cyc_drive();
    if_ready = 1'b1;
    wait_hs(5, c);

    // Redirect while waiting; in-flight response must be dropped
    cyc_drive();
    cyc_drive();
    redirect = 1'b1;
    redirect_pc = 32'h00400100;
    cyc_drive();
    redirect = 1'b0;
    @(negedge clk);
    chk("drop_vld", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h00400100);
    wait_hs(10, c);
    chk("redir_if_pc", if_pc, 32'h00400100);

    // Redirect in HOLD with if_ready high flushes without counting
    cyc_drive();
    if_ready = 1'b0;
    wait_vld(10);
    cyc_drive();
    if_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h00500000;
    cyc_drive();
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_cnt", fetch_cnt, 32'd5);
    chk("flush_vld", 32'(if_valid), 32'd0);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", imem_addr, 32'h00500000);

    // Randomized traffic
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc_drive();
      if_ready = ($urandom_range(0, 3) != 0);
      redirect = !redirect && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3));
      else redirect_pc = $urandom() & 32'hFFFFFFFC;
    end
    cyc_drive();
    redirect = 1'b0;

    // PC wrap at the top of the address space
    cyc_drive();
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    cyc_drive();
    redirect = 1'b0;
    if_ready = 1'b1;
    wait_hs(20, c);
    chk("wrap_pc", if_pc, 32'hFFFFFFFC);
    chk("wrap_npc", npc, 32'h00000000);
    chk("wrap_pc_en", 32'(pc_en), 32'd1);

    // Reset in the middle of a fetch
    lat_mode = 3;
    cyc_drive();
    cyc_drive();
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_npc", npc, START);
    chk("midrst_pc_en", 32'(pc_en), 32'd1);
    chk("midrst_vld", 32'(if_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_cnt", fetch_cnt, 32'd0);

    // IMEM timeout
    mute = 1'b1;
    cyc_drive();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("to_err_early", 32'(fetch_err), 32'd0);
    chk("to_req_wait", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req_halt", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc_drive();
      redirect = (i == 1);
      redirect_pc = 32'h00001234;
      @(negedge clk);
      chk("halt_err", 32'(fetch_err), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc_en", 32'(pc_en), 32'd0);
      chk("halt_vld", 32'(if_valid), 32'd0);
    end
    cyc_drive();
    redirect = 1'b0;
    mute = 1'b0;
    lat_mode = 1;
    restart();
    wait_hs(10, c);
    chk("recover_pc", if_pc, START);
    chk("recover_err", 32'(fetch_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
